// File: rtl/rr_pkg.sv
// rr_pkg: shared types and helpers for the round-robin grant consumer.
//   rr_state_e    : consumer FSM states
//   is_onehot     : true when exactly one bit of a vector is set
//   onehot_to_idx : bit position of the (single) set bit of a vector
//   IDX_W         : client index width for the default client count
// Vector helpers operate on VEC_W bits, so client counts up to 32 are supported.
package rr_pkg;

  localparam int RR_WIDTH = 8;
  localparam int IDX_W    = $clog2(RR_WIDTH);
  localparam int VEC_W    = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARB     = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } rr_state_e;

  function automatic logic is_onehot(input logic [VEC_W-1:0] v);
    return (v != '0) && ((v & (v - VEC_W'(1))) == '0);
  endfunction

  // Intended for one-hot inputs; with several bits set the highest wins.
  function automatic int onehot_to_idx(input logic [VEC_W-1:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < VEC_W; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_out_slice.sv
// rr_out_slice: single-entry valid/ready output register holding one beat
// (data, source index, last flag).
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : capture data_i/src_i/last_i this cycle (caller guarantees
//                   the slot is free or draining)
//   ready_i       : downstream ready
//   valid_o, data_o, src_o, last_o : registered beat
module rr_out_slice #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [IDX_W-1:0]  src_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [IDX_W-1:0]  src_o,
  output logic              last_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]  src_q, src_d;
  logic              last_q, last_d;

  // A load wins over a drain, so load-and-drain in one cycle keeps valid high.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    src_d   = src_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      src_d   = src_i;
      last_d  = last_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      src_q   <= src_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign src_o   = src_q;
  assign last_o  = last_q;

endmodule

// File: rtl/rr_grant_consumer.sv
// rr_grant_consumer: client side of a round-robin arbiter. Publishes pending
// client beats as req_o, samples the one-hot grant_i, forwards up to
// MAX_BEATS beats of the granted client through a registered output stage and
// pulses ack_o once the grant is used up so the arbiter rotates.
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   cli_valid_i/last_i/data_i: per-client beat streams (client i data at
//                              [i*DATA_W +: DATA_W])
//   cli_ready_o              : per-client beat accepted
//   req_o, grant_i, ack_o    : arbiter handshake
//   out_valid_o, out_ready_i, out_data_o, out_src_o, out_last_o : output beat
//   err_o                    : sticky protocol error (bad grant)
module rr_grant_consumer
  import rr_pkg::*;
#(
  parameter int WIDTH     = RR_WIDTH,
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 4,
  localparam int SRC_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [WIDTH-1:0]        cli_valid_i,
  input  logic [WIDTH-1:0]        cli_last_i,
  input  logic [WIDTH*DATA_W-1:0] cli_data_i,
  output logic [WIDTH-1:0]        cli_ready_o,
  output logic [WIDTH-1:0]        req_o,
  input  logic [WIDTH-1:0]        grant_i,
  output logic                    ack_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [DATA_W-1:0]       out_data_o,
  output logic [SRC_W-1:0]        out_src_o,
  output logic                    out_last_o,
  output logic                    err_o
);

  localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  rr_state_e         state_q, state_d;
  logic [SRC_W-1:0]  g_q, g_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] cli_data_a [WIDTH];
  logic [VEC_W-1:0]  grant_w;
  logic              grant_ok;
  logic              beat_rdy;
  logic              beat_acc;
  logic              beat_last;
  logic              slot_valid;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      cli_data_a[i] = cli_data_i[i*DATA_W +: DATA_W];
    end
  end

  assign grant_w  = VEC_W'(grant_i);
  // Legal only if one-hot and the granted client actually has a beat waiting.
  assign grant_ok = is_onehot(grant_w) && ((grant_i & cli_valid_i) != '0);

  assign beat_acc  = cli_valid_i[g_q] & beat_rdy;
  // The grant ends on the client's own last beat or when the beat budget is
  // spent; a truncated burst simply resumes on the client's next grant.
  assign beat_last = cli_last_i[g_q] | (cnt_q == CNT_W'(MAX_BEATS - 1));

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      g_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (cli_valid_i != '0) state_d = ARB;
      end
      ARB: begin
        if (cli_valid_i == '0) begin
          state_d = IDLE;
        end else if (grant_i != '0) begin
          if (grant_ok) begin
            g_d     = SRC_W'(onehot_to_idx(grant_w));
            cnt_d   = '0;
            state_d = XFER;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      XFER: begin
        if (beat_acc) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (beat_last) state_d = RELEASE;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    req_o       = '0;
    cli_ready_o = '0;
    ack_o       = 1'b0;
    beat_rdy    = 1'b0;
    case (state_q)
      IDLE, ARB: begin
        req_o = cli_valid_i;
      end
      XFER: begin
        beat_rdy         = !slot_valid | out_ready_i;
        cli_ready_o[g_q] = beat_rdy;
      end
      RELEASE: begin
        ack_o = 1'b1;
      end
      default: begin
        ack_o = 1'b0;
      end
    endcase
  end

  rr_out_slice #(
    .DATA_W (DATA_W),
    .IDX_W  (SRC_W)
  ) u_out_slice (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (beat_acc),
    .data_i  (cli_data_a[g_q]),
    .src_i   (g_q),
    .last_i  (beat_last),
    .ready_i (out_ready_i),
    .valid_o (slot_valid),
    .data_o  (out_data_o),
    .src_o   (out_src_o),
    .last_o  (out_last_o)
  );

  assign out_valid_o = slot_valid;
  assign err_o       = err_q;

endmodule

// File: tb/tb_rr_grant_consumer.sv
// Self-checking bench for rr_grant_consumer: per-client beat sources, a
// rotating-priority arbiter model and a per-client scoreboard whose expected
// out_last flags come from splitting each burst into MAX_BEATS chunks.
module tb_rr_grant_consumer;

  localparam int WIDTH     = 8;
  localparam int DATA_W    = 8;
  localparam int MAX_BEATS = 4;
  localparam int SRC_W     = 3;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [WIDTH-1:0]        cli_valid;
  logic [WIDTH-1:0]        cli_last;
  logic [WIDTH*DATA_W-1:0] cli_data;
  logic [WIDTH-1:0]        cli_ready;
  logic [WIDTH-1:0]        req;
  logic [WIDTH-1:0]        grant;
  logic                    ack;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;
  logic [SRC_W-1:0]        out_src;
  logic                    out_last;
  logic                    err;

  rr_grant_consumer #(
    .WIDTH     (WIDTH),
    .DATA_W    (DATA_W),
    .MAX_BEATS (MAX_BEATS)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cli_valid_i (cli_valid),
    .cli_last_i  (cli_last),
    .cli_data_i  (cli_data),
    .cli_ready_o (cli_ready),
    .req_o       (req),
    .grant_i     (grant),
    .ack_o       (ack),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_src_o   (out_src),
    .out_last_o  (out_last),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  beat_t srcq [WIDTH][$];
  beat_t expq [WIDTH][$];

  int n_chk  = 0;
  int n_fail = 0;

  int               ptr, owner, ack_cnt;
  int               ack_list[$];
  logic             arb_en, gap_en, err_exp;
  int               ready_mode;
  logic [WIDTH-1:0] man_grant, acc;
  logic             prev_free, prev_valid, prev_ready, prev_last;
  logic [DATA_W-1:0] prev_data;
  logic [SRC_W-1:0]  prev_src;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Source beats plus the output the consumer must produce for them: each
  // grant forwards at most MAX_BEATS, so last marks burst end or chunk end.
  task automatic add_burst(input int cli, input int n, input logic [DATA_W-1:0] base);
    beat_t b, e;
    for (int k = 0; k < n; k++) begin
      b.data = base + DATA_W'(k);
      b.last = (k == n - 1);
      e.data = b.data;
      e.last = b.last || ((k % MAX_BEATS) == MAX_BEATS - 1);
      srcq[cli].push_back(b);
      expq[cli].push_back(e);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < WIDTH; i++) begin
      if (srcq[i].size() > 0) begin
        cli_valid[i] = gap_en ? ($urandom_range(3) != 0) : 1'b1;
        cli_last[i]  = srcq[i][0].last;
        cli_data[i*DATA_W +: DATA_W] = srcq[i][0].data;
      end else begin
        cli_valid[i] = 1'b0;
        cli_last[i]  = 1'b0;
        cli_data[i*DATA_W +: DATA_W] = '0;
      end
    end
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(2) != 0);
      default: out_ready = 1'b0;
    endcase
  endtask

  task automatic sample();
    int s;
    logic new_beat;
    logic [WIDTH-1:0] g;
    new_beat = out_valid && prev_free;
    if (!prev_free) begin
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_data", out_data, prev_data);
      check_eq("hold_src", out_src, prev_src);
      check_eq("hold_last", out_last, prev_last);
    end else if (new_beat) begin
      s = int'(out_src);
      check_eq("sb_nonempty", expq[s].size() > 0, 1);
      if (expq[s].size() > 0) begin
        check_eq("beat_data", out_data, expq[s][0].data);
        check_eq("beat_last", out_last, expq[s][0].last);
        void'(expq[s].pop_front());
      end
      if (arb_en) check_eq("src_owner", out_src, owner);
    end
    check_eq("ack_align", ack, new_beat && out_last);
    if (ack) begin
      check_eq("ack_req_low", req, 0);
      ack_cnt++;
      ack_list.push_back(owner);
      ptr = (owner + 1) % WIDTH;
    end
    if (cli_ready != '0) begin
      check_eq("ready_owner", cli_ready, 32'(1) << owner);
      check_eq("xfer_req_low", req, 0);
    end
    check_eq("err", err, err_exp);
    acc        = cli_valid & cli_ready;
    prev_valid = out_valid;
    prev_ready = out_ready;
    prev_data  = out_data;
    prev_src   = out_src;
    prev_last  = out_last;
    prev_free  = !out_valid || out_ready;
    // Arbiter model: first requester at or after the priority pointer.
    g = '0;
    if (arb_en) begin
      for (int k = 0; k < WIDTH; k++) begin
        if (req[(ptr + k) % WIDTH]) begin
          g[(ptr + k) % WIDTH] = 1'b1;
          break;
        end
      end
    end else begin
      g = man_grant;
    end
    if ($countones(g) == 1) begin
      for (int k = 0; k < WIDTH; k++) if (g[k]) owner = k;
    end
    grant = g;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < WIDTH; i++) begin
      if (acc[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    end
    acc = '0;
    drive();
    @(negedge clk);
    sample();
  endtask

  function automatic logic busy();
    logic b;
    b = out_valid;
    for (int i = 0; i < WIDTH; i++) begin
      if (srcq[i].size() > 0 || expq[i].size() > 0) b = 1'b1;
    end
    return b;
  endfunction

  task automatic run_drain(input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    check_eq("drain_timeout", n < budget, 1);
    repeat (3) step();
  endtask

  task automatic wait_out_valid(input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!out_valid && n < budget);
    check_eq("wait_valid", out_valid, 1);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    cli_valid = '0;
    cli_last  = '0;
    cli_data  = '0;
    grant     = '0;
    acc       = '0;
    for (int i = 0; i < WIDTH; i++) begin
      srcq[i].delete();
      expq[i].delete();
    end
    #1;
    check_eq("rst_cli_ready", cli_ready, 0);
    check_eq("rst_req", req, 0);
    check_eq("rst_ack", ack, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_src", out_src, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_err", err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n      = 1'b1;
    prev_free  = 1'b1;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    ptr        = 0;
    owner      = 0;
    err_exp    = 1'b0;
  endtask

  initial begin
    int a0;
    rst_n      = 1'b1;
    cli_valid  = '0;
    cli_last   = '0;
    cli_data   = '0;
    grant      = '0;
    out_ready  = 1'b1;
    arb_en     = 1'b1;
    gap_en     = 1'b0;
    ready_mode = 0;
    man_grant  = '0;
    ack_cnt    = 0;
    #2;
    do_reset();

    // Single client, three-beat burst.
    add_burst(2, 3, 8'hA1);
    a0 = ack_cnt;
    run_drain(100);
    check_eq("single_acks", ack_cnt - a0, 1);

    // Six-beat burst split by the beat budget.
    add_burst(0, 6, 8'h10);
    a0 = ack_cnt;
    run_drain(100);
    check_eq("trunc_acks", ack_cnt - a0, 2);

    // Backpressure mid-burst.
    add_burst(4, 4, 8'h50);
    wait_out_valid(30);
    ready_mode = 2;
    repeat (5) begin
      step();
      check_eq("bp_cli_ready", cli_ready, 0);
      check_eq("bp_out_valid", out_valid, 1);
    end
    ready_mode = 0;
    run_drain(100);

    // Grant to a client without a valid beat.
    arb_en    = 1'b0;
    man_grant = '0;
    add_burst(0, 2, 8'h20);
    add_burst(1, 2, 8'h28);
    repeat (3) step();
    check_eq("arb_req", req, 8'h03);
    man_grant = 8'h20;
    step();
    man_grant = '0;
    err_exp   = 1'b1;
    step();
    check_eq("e5_no_ready", cli_ready, 0);
    do_reset();

    // Multi-hot grant, then a legal grant completes.
    add_burst(0, 2, 8'h20);
    add_burst(1, 2, 8'h28);
    repeat (3) step();
    man_grant = 8'h03;
    step();
    man_grant = '0;
    err_exp   = 1'b1;
    step();
    repeat (2) step();
    check_eq("mh_no_ready", cli_ready, 0);
    check_eq("mh_still_arb", req, 8'h03);
    arb_en = 1'b1;
    a0 = ack_cnt;
    run_drain(100);
    check_eq("mh_acks", ack_cnt - a0, 2);
    do_reset();

    // Contention among clients 1, 3, 6.
    ack_list.delete();
    add_burst(1, 2, 8'h30);
    add_burst(3, 3, 8'h40);
    add_burst(6, 1, 8'h60);
    run_drain(200);
    check_eq("cont_nacks", ack_list.size(), 3);
    if (ack_list.size() == 3) begin
      check_eq("cont_order0", ack_list[0], 1);
      check_eq("cont_order1", ack_list[1], 3);
      check_eq("cont_order2", ack_list[2], 6);
    end

    // Randomized traffic, gaps and backpressure.
    gap_en     = 1'b1;
    ready_mode = 1;
    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < 5; j++) begin
        add_burst($urandom_range(WIDTH - 1), $urandom_range(7, 1), DATA_W'($urandom));
      end
      run_drain(3000);
    end

    // Reset while a beat sits in the output register.
    gap_en     = 1'b0;
    ready_mode = 0;
    add_burst(3, 4, 8'h70);
    wait_out_valid(30);
    a0 = ack_cnt;
    do_reset();
    repeat (6) step();
    check_eq("rst_no_ack", ack_cnt - a0, 0);
    check_eq("rst_idle_valid", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
